// File: rtl/compressor_pkg.sv
// -----------------------------------------------------------------------------
// compressor_pkg
// Shared definitions for the compressor test-harness blocks.
//   CNT_W(w)     : width of a counter that must hold values 0..w inclusive
//   shift_dir_e  : which end of a lane the first serial bit finally lands in
// -----------------------------------------------------------------------------
package compressor_pkg;

    // DIR_MSB_FIRST: new bit enters bit 0, so the first bit ends at the MSB.
    // DIR_LSB_FIRST: new bit enters the top bit, so the first bit ends at the LSB.
    typedef enum logic {
        DIR_MSB_FIRST = 1'b0,
        DIR_LSB_FIRST = 1'b1
    } shift_dir_e;

    function automatic int CNT_W(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/operand_shift_lane.sv
// -----------------------------------------------------------------------------
// operand_shift_lane
// One serial-to-parallel lane of the operand loader.
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset, clears the lane
//   i_shift  in   shift i_bit into the lane this cycle
//   i_bit    in   serial input bit
//   i_clear  in   clear the lane (word has been emitted)
//   i_count  in   number of valid bits in the post-shift lane
//   o_word   out  post-shift lane contents, aligned for emission
// -----------------------------------------------------------------------------
module operand_shift_lane
    import compressor_pkg::*;
#(
    parameter int WIDTH     = 21,
    parameter int LSB_FIRST = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_shift,
    input  logic                    i_bit,
    input  logic                    i_clear,
    input  logic [CNT_W(WIDTH)-1:0] i_count,
    output logic [WIDTH-1:0]        o_word
);

    localparam int         CW  = CNT_W(WIDTH);
    localparam shift_dir_e DIR = (LSB_FIRST != 0) ? DIR_LSB_FIRST : DIR_MSB_FIRST;

    logic [WIDTH-1:0] r_lane;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_mask;

    always_comb begin
        w_next = r_lane;
        if (i_shift) begin
            w_next = (DIR == DIR_LSB_FIRST) ? {i_bit, r_lane[WIDTH-1:1]}
                                            : {r_lane[WIDTH-2:0], i_bit};
        end
    end

    // Lanes are cleared after every emission, so unfilled bits are already 0.
    // MSB-first words sit right-aligned; the mask only guards that invariant.
    // LSB-first words fill from the top and must be pulled down to bit 0.
    // A shift by i_count==WIDTH yields 0, so the mask becomes all ones.
    assign w_mask = ~({WIDTH{1'b1}} << i_count);
    assign o_word = (DIR == DIR_LSB_FIRST) ? (w_next >> (CW'(WIDTH) - i_count))
                                           : (w_next & w_mask);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_lane <= '0;
        end else begin
            r_lane <= w_next;
        end
    end

endmodule

// File: rtl/operand_shift_loader.sv
// -----------------------------------------------------------------------------
// operand_shift_loader
// Shifts NUM_SRC one-bit serial streams into WIDTH-bit lanes and emits the
// complete (or flushed partial) operand words over a valid/ready handshake.
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   in_valid   in   in_bits holds one bit per channel
//   in_ready   out  a beat is accepted this cycle (combinational)
//   in_bits    in   bit i feeds channel i
//   flush      in   emit the partially filled word now
//   out_valid  out  out_data/out_count hold a word
//   out_ready  in   consumer takes the word
//   out_data   out  channel i at [i*WIDTH +: WIDTH]
//   out_count  out  valid bits per lane (WIDTH when full)
// -----------------------------------------------------------------------------
module operand_shift_loader
    import compressor_pkg::*;
#(
    parameter int NUM_SRC   = 21,
    parameter int WIDTH     = 21,
    parameter int LSB_FIRST = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC-1:0]       in_bits,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_SRC*WIDTH-1:0] out_data,
    output logic [CNT_W(WIDTH)-1:0]  out_count
);

    localparam int            CW       = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0]            r_cnt;
    logic [CW-1:0]            w_cnt_next;
    logic                     w_accept;
    logic                     w_emit;
    logic [NUM_SRC*WIDTH-1:0] w_words;

    // No skid buffer: a pending word blocks input until it is taken.
    assign in_ready   = !out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_next = r_cnt + CW'(w_accept);

    // Flush emits only when there is something to send, counting a beat
    // accepted on the same edge; w_cnt_next != 0 covers both cases.
    assign w_emit = (w_accept && (r_cnt == LAST_CNT)) ||
                    (flush && in_ready && (w_cnt_next != '0));

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        operand_shift_lane #(
            .WIDTH     (WIDTH),
            .LSB_FIRST (LSB_FIRST)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .i_shift (w_accept),
            .i_bit   (in_bits[g]),
            .i_clear (w_emit),
            .i_count (w_cnt_next),
            .o_word  (w_words[g*WIDTH +: WIDTH])
        );
    end

    // An emission on the same edge as a consume keeps out_valid high,
    // so consecutive words go out without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
        end else if (w_emit) begin
            r_cnt     <= '0;
            out_valid <= 1'b1;
            out_data  <= w_words;
            out_count <= w_cnt_next;
        end else begin
            r_cnt <= w_cnt_next;
            if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_shift_loader.sv
// -----------------------------------------------------------------------------
// tb_operand_shift_loader
// Two loaders (MSB-first and LSB-first) share one stimulus stream. A small
// bench model collects accepted beats and pushes the expected word onto a
// scoreboard queue when it should be emitted; scenario tasks pop and compare.
// -----------------------------------------------------------------------------
module tb_operand_shift_loader;

    localparam int NS = 3;
    localparam int W  = 4;
    localparam int DW = NS * W;
    localparam int CW = 3;

    typedef struct {
        logic [CW-1:0] cnt;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [NS-1:0] in_bits = '0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b1;

    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [DW-1:0] data0, data1;
    logic [CW-1:0] cnt0, cnt1;

    int vectors     = 0;
    int miscompares = 0;

    exp_t          sb[$];
    logic [NS-1:0] beats[$];
    logic          m_ovalid = 1'b0;

    always #5 clk = ~clk;

    operand_shift_loader #(.NUM_SRC(NS), .WIDTH(W), .LSB_FIRST(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_bits(in_bits), .flush(flush), .out_valid(out_valid0),
        .out_ready(out_ready), .out_data(data0), .out_count(cnt0)
    );

    operand_shift_loader #(.NUM_SRC(NS), .WIDTH(W), .LSB_FIRST(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_bits(in_bits), .flush(flush), .out_valid(out_valid1),
        .out_ready(out_ready), .out_data(data1), .out_count(cnt1)
    );

    // Expected word from the collected beats: MSB-first puts beat k at
    // position n-1-k (right-aligned), LSB-first puts beat k at position k.
    function automatic logic [DW-1:0] model(input bit lsb);
        logic [DW-1:0] r;
        int n;
        r = '0;
        n = beats.size();
        for (int ch = 0; ch < NS; ch++)
            for (int k = 0; k < n; k++)
                if (lsb) r[ch*W + k] = beats[k][ch];
                else     r[ch*W + (n-1-k)] = beats[k][ch];
        return r;
    endfunction

    // Drive one cycle of inputs, clock, and advance the bench model.
    task automatic drive(input logic v, input logic [NS-1:0] b,
                         input logic fl, input logic ordy);
        logic rdy, emit;
        in_valid  = v;
        in_bits   = b;
        flush     = fl;
        out_ready = ordy;
        rdy = !m_ovalid || ordy;
        @(posedge clk);
        #1;
        if (rst) begin
            beats.delete();
            sb.delete();
            m_ovalid = 1'b0;
        end else begin
            if (v && rdy) beats.push_back(b);
            emit = (beats.size() == W) || (fl && rdy && beats.size() > 0);
            if (emit) begin
                sb.push_back('{cnt: CW'(beats.size()), d0: model(0), d1: model(1)});
                beats.delete();
                m_ovalid = 1'b1;
            end else if (ordy) begin
                m_ovalid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 3'b111, 1'b1, 1'b1);
        drive(1'b1, 3'b111, 1'b1, 1'b1);
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_valid: got %b/%b want 0", out_valid0, out_valid1);
        end
        vectors++;
        if (data0 !== '0 || cnt0 !== '0 || data1 !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%0d/%h want 0", data0, cnt0, data1);
        end
        vectors++;
        if (in_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready0);
        end
    endtask

    task automatic test_full_word();
        exp_t e;
        drive(1'b1, 3'b001, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        drive(1'b1, 3'b100, 1'b0, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL full_early_valid: got %b want 0", out_valid0);
        end
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b1 || cnt0 !== 3'd4 || data0 !== 12'b0011_0101_1001) begin
            miscompares++;
            $display("FAIL full_word: got v=%b cnt=%0d data=%b want v=1 cnt=4 data=001101011001",
                     out_valid0, cnt0, data0);
        end
        if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL full_sb: got empty scoreboard want 1 entry");
        end else begin
            e = sb.pop_front();
            vectors++;
            if (out_valid1 !== 1'b1 || data1 !== e.d1 || cnt1 !== e.cnt) begin
                miscompares++;
                $display("FAIL full_word_lsb: got v=%b data=%b cnt=%0d want v=1 data=%b cnt=%0d",
                         out_valid1, data1, cnt1, e.d1, e.cnt);
            end
        end
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL full_consume: got out_valid=%b want 0", out_valid0);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        logic [DW-1:0] held;
        drive(1'b1, 3'b101, 1'b0, 1'b0);
        drive(1'b1, 3'b011, 1'b0, 1'b0);
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        drive(1'b1, 3'b000, 1'b0, 1'b0);
        held = data0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b111, 1'b0, 1'b0);
            vectors++;
            if (in_ready0 !== 1'b0 || out_valid0 !== 1'b1 || data0 !== held) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got rdy=%b v=%b data=%h want rdy=0 v=1 data=%h",
                         i, in_ready0, out_valid0, data0, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready0 !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready0);
        end
        e = sb.pop_front();
        vectors++;
        if (data0 !== e.d0 || data1 !== e.d1 || cnt0 !== e.cnt) begin
            miscompares++;
            $display("FAIL bp_word: got %h/%h/%0d want %h/%h/%0d",
                     data0, data1, cnt0, e.d0, e.d1, e.cnt);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        // Counter must still be 0: three beats are not enough for a word.
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        drive(1'b1, 3'b010, 1'b0, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_cnt_kept: got out_valid=%b after 3 beats want 0", out_valid0);
        end
        drive(1'b1, 3'b101, 1'b0, 1'b1);
        e = sb.pop_front();
        vectors++;
        if (out_valid0 !== 1'b1 || data0 !== e.d0 || data1 !== e.d1 || cnt0 !== e.cnt) begin
            miscompares++;
            $display("FAIL bp_next_word: got v=%b %h/%h/%0d want v=1 %h/%h/%0d",
                     out_valid0, data0, data1, cnt0, e.d0, e.d1, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [NS-1:0] b;
        for (int i = 0; i < 8; i++) begin
            b = NS'($urandom_range(0, 7));
            vectors++;
            if (in_ready0 !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready0);
            end
            drive(1'b1, b, 1'b0, 1'b1);
            if (i == 3 || i == 7) begin
                e = sb.pop_front();
                vectors++;
                if (out_valid0 !== 1'b1 || data0 !== e.d0 || data1 !== e.d1 || cnt0 !== e.cnt) begin
                    miscompares++;
                    $display("FAIL b2b_word[%0d]: got v=%b %h/%h/%0d want v=1 %h/%h/%0d",
                             i, out_valid0, data0, data1, cnt0, e.d0, e.d1, e.cnt);
                end
            end
        end
        // Flush on every beat: each edge consumes one word and emits the next.
        for (int i = 0; i < 3; i++) begin
            b = NS'(i + 3);
            drive(1'b1, b, 1'b1, 1'b1);
            e = sb.pop_front();
            vectors++;
            if (out_valid0 !== 1'b1 || cnt0 !== 3'd1 || data0 !== e.d0 || data1 !== e.d1) begin
                miscompares++;
                $display("FAIL b2b_flush[%0d]: got v=%b cnt=%0d %h/%h want v=1 cnt=1 %h/%h",
                         i, out_valid0, cnt0, data0, data1, e.d0, e.d1);
            end
        end
        drive(1'b0, 3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_flush_partial();
        exp_t e;
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b1, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b1 || cnt0 !== 3'd2 || data0 !== 12'h333) begin
            miscompares++;
            $display("FAIL flush_msb: got v=%b cnt=%0d data=%h want v=1 cnt=2 data=333",
                     out_valid0, cnt0, data0);
        end
        vectors++;
        if (out_valid1 !== 1'b1 || cnt1 !== 3'd2 || data1 !== 12'h333) begin
            miscompares++;
            $display("FAIL flush_lsb: got v=%b cnt=%0d data=%h want v=1 cnt=2 data=333",
                     out_valid1, cnt1, data1);
        end
        e = sb.pop_front();
        drive(1'b0, 3'b000, 1'b0, 1'b1);
    endtask

    task automatic test_flush_same_cycle();
        exp_t e;
        drive(1'b1, 3'b101, 1'b0, 1'b1);
        drive(1'b1, 3'b011, 1'b0, 1'b1);
        drive(1'b1, 3'b110, 1'b1, 1'b1);
        e = sb.pop_front();
        vectors++;
        if (out_valid0 !== 1'b1 || cnt0 !== 3'd3 || data0 !== e.d0 || data1 !== e.d1) begin
            miscompares++;
            $display("FAIL flush_same: got v=%b cnt=%0d %h/%h want v=1 cnt=3 %h/%h",
                     out_valid0, cnt0, data0, data1, e.d0, e.d1);
        end
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        drive(1'b0, 3'b000, 1'b1, 1'b1);
        drive(1'b0, 3'b000, 1'b1, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_empty: got out_valid=%b/%b want 0", out_valid0, out_valid1);
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_mid_word();
        exp_t e;
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        drive(1'b1, 3'b111, 1'b0, 1'b1);
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b000, 1'b0, 1'b1);
        vectors++;
        if (out_valid0 !== 1'b1 || cnt0 !== 3'd4 || data0 !== '0 || data1 !== '0) begin
            miscompares++;
            $display("FAIL reset_residue: got v=%b cnt=%0d %h/%h want v=1 cnt=4 000/000",
                     out_valid0, cnt0, data0, data1);
        end
        e = sb.pop_front();
        // Reset while a word is pending discards it.
        for (int i = 0; i < 4; i++) drive(1'b1, 3'b111, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        rst = 1'b0;
        vectors++;
        if (out_valid0 !== 1'b0 || data0 !== '0 || cnt0 !== '0) begin
            miscompares++;
            $display("FAIL reset_pending: got v=%b data=%h cnt=%0d want 0/000/0",
                     out_valid0, data0, cnt0);
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_backpressure();
        test_back_to_back();
        test_flush_partial();
        test_flush_same_cycle();
        test_reset_mid_word();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drained: got %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
